// File: rtl/fib_pkg.sv
// Shared constants for the Fibonacci datapath: push-source encoding, default sizes
// and the stack operation decode used by fib_stack.
package fib_pkg;

  localparam logic [1:0] SRC_FLAG = 2'd0;
  localparam logic [1:0] SRC_N    = 2'd1;
  localparam logic [1:0] SRC_RES  = 2'd2;
  localparam logic [1:0] SRC_RSVD = 2'd3;

  localparam int unsigned FIB_WIDTH       = 16;
  localparam int unsigned FIB_STACK_DEPTH = 32;

  typedef enum logic [1:0] {
    OpIdle,
    OpPush,
    OpPop,
    OpReplace
  } stackOp_e;

  function automatic stackOp_e decodeOp(input logic push, input logic pop);
    stackOp_e op;
    case ({push, pop})
      2'b10:   op = OpPush;
      2'b01:   op = OpPop;
      2'b11:   op = OpReplace;
      default: op = OpIdle;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/fib_stack_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module fib_stack_mem
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH = FIB_WIDTH,
  parameter int unsigned DEPTH = FIB_STACK_DEPTH,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fib_stack.sv
// LIFO datapath for the Fibonacci controller; top-of-stack is combinational so pops
// load downstream registers on the same edge. Macro FIB_STACK_HWM_EN adds hwm output.
module fib_stack
  import fib_pkg::*;
#(
  parameter int unsigned WIDTH = FIB_WIDTH,
  parameter int unsigned DEPTH = FIB_STACK_DEPTH,
  parameter int unsigned PTR_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [1:0]       pushSrc,
  input  logic [WIDTH-1:0] flagIn,
  input  logic [WIDTH-1:0] nIn,
  input  logic [WIDTH-1:0] resIn,
  output logic [WIDTH-1:0] dataOut,
  output logic             empty,
  output logic             full,
  output logic [PTR_W-1:0] count,
  output logic             ovf,
  output logic             unf
`ifdef FIB_STACK_HWM_EN
  ,
  output logic [PTR_W-1:0] hwm
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PtrFull = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] PtrOne  = PTR_W'(1);

  logic [PTR_W-1:0] spQ, spD;
  logic             ovfQ, ovfD;
  logic             unfQ, unfD;
  logic             isEmpty, isFull;
  logic [WIDTH-1:0] pushData;
  logic [WIDTH-1:0] memRdata;
  logic             memWe;
  logic [AW-1:0]    memWaddr;
  logic [AW-1:0]    topAddr;
  stackOp_e         op;

  assign isEmpty = (spQ == '0);
  assign isFull  = (spQ == PtrFull);
  assign topAddr = AW'(spQ - PtrOne);
  assign op      = decodeOp(push, pop);

  always_comb begin
    pushData = '0;
    case (pushSrc)
      SRC_FLAG: pushData = flagIn;
      SRC_N:    pushData = nIn;
      SRC_RES:  pushData = resIn;
      default:  pushData = '0;
    endcase
  end

  always_comb begin
    spD      = spQ;
    ovfD     = ovfQ;
    unfD     = unfQ;
    memWe    = 1'b0;
    memWaddr = AW'(spQ);
    case (op)
      OpPush: begin
        if (isFull) begin
          ovfD = 1'b1;
        end else begin
          memWe = 1'b1;
          spD   = spQ + PtrOne;
        end
      end
      OpPop: begin
        if (isEmpty) begin
          unfD = 1'b1;
        end else begin
          spD = spQ - PtrOne;
        end
      end
      OpReplace: begin
        // Both strobes: overwrite the top in place, or behave as a plain push when empty.
        memWe = 1'b1;
        if (isEmpty) begin
          spD = spQ + PtrOne;
        end else begin
          memWaddr = topAddr;
        end
      end
      default: ;
    endcase
    // Reset abandons any in-flight operation, including its write.
    if (!rst_n) begin
      memWe = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      spQ  <= '0;
      ovfQ <= 1'b0;
      unfQ <= 1'b0;
    end else begin
      spQ  <= spD;
      ovfQ <= ovfD;
      unfQ <= unfD;
    end
  end

  fib_stack_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (memWe),
    .waddr (memWaddr),
    .wdata (pushData),
    .raddr (topAddr),
    .rdata (memRdata)
  );

  assign dataOut = isEmpty ? '0 : memRdata;
  assign empty   = isEmpty;
  assign full    = isFull;
  assign count   = spQ;
  assign ovf     = ovfQ;
  assign unf     = unfQ;

`ifdef FIB_STACK_HWM_EN
  logic [PTR_W-1:0] hwmQ;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hwmQ <= '0;
    end else if (spD > hwmQ) begin
      hwmQ <= spD;
    end
  end

  assign hwm = hwmQ;
`endif

endmodule
